datastream_arbiter: RTL
=======================

Name: datastream_arbiter

Overview:
- Round-robin, burst-locked arbiter sharing one datastream analyzer input between NBSOURCES valid/ready source streams.
- A grant is held for exactly BURSTLEN accepted words, so the analyzer always sees contiguous, window-aligned data from one source.
- Sits directly upstream of the analyzer. grant_id_o tags which source the analyzer is currently processing.

Parameters:
- NBSOURCES, 4, number of requesting streams (2..16)
- DATASIZE, 8, data width, equal to the analyzer DATASIZE
- BURSTLEN, 4, words per grant; set to the analyzer WINDOWSIZE (>=1)
- TIMEOUT, 16, idle-valid cycles before a stalled burst is aborted (used only with ARB_TIMEOUT_EN)

Ports:
- clk_i  in  1  single clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- src_data_i  in  NBSOURCES*DATASIZE  source data; source k occupies bits [k*DATASIZE +: DATASIZE]
- src_valid_i  in  NBSOURCES  per-source valid
- src_ready_o  out  NBSOURCES  per-source ready
- data_o  out  DATASIZE  to analyzer data_i
- valid_o  out  1  to analyzer valid_i
- ready_i  in  1  from analyzer ready_o
- grant_id_o  out  $clog2(NBSOURCES)  currently granted source
- busy_o  out  1  high in BURST state
- burst_done_o  out  1  one-cycle pulse on the last transfer of a burst
- timeout_o  out  1  one-cycle pulse on burst abort (always 0 without ARB_TIMEOUT_EN)

Behaviour:
- Reset (rst_i=0, asynchronous):
  - state=IDLE, count=0, grant_id_o=0, last_grant=NBSOURCES-1.
  - All outputs 0; src_ready_o all 0.
- Transfer definition: valid_o & ready_i in BURST.
- FSM IDLE:
  - valid_o=0, src_ready_o=0, busy_o=0.
  - If any src_valid_i bit is set, grant the first set bit searching from last_grant+1 upward, wrapping modulo NBSOURCES.
  - Register the grant into grant_id_o and last_grant; go to BURST.
  - Arbitration latency: 1 cycle from request to valid_o.
- FSM BURST:
  - data_o = slice of src_data_i selected by grant_id_o (combinational mux).
  - valid_o = src_valid_i[grant_id_o].
  - src_ready_o[grant_id_o] = ready_i; all other ready bits 0.
  - Each transfer increments count.
  - Transfer with count==BURSTLEN-1: burst_done_o=1 that cycle; next state IDLE; count cleared.
- Grant is locked:
  - Granted source deasserting valid mid-burst stalls the burst; there is no re-arbitration.
  - Other sources' valid changes are ignored until IDLE.
- Fairness: one bubble cycle (IDLE) between bursts; a requester waits at most NBSOURCES-1 bursts.
- Single requester repeatedly granted: bursts separated by one IDLE cycle.
- grant_id_o holds its value in IDLE; it is meaningful only while busy_o=1.
- Reset mid-burst: immediate return to IDLE; the partial burst is lost. The analyzer must be reset together with this block.
- No combinational path from src_valid_i to src_ready_o except through valid_o in BURST. ready_i reaches src_ready_o combinationally.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A counter increments each BURST cycle with src_valid_i[grant_id_o]=0 and clears on any cycle with valid=1.
  - Counter reaching TIMEOUT: timeout_o pulses, burst aborts to IDLE, count cleared.
  - last_grant keeps the aborting source, so the next search starts after it.
- Not defined: no counter; timeout_o tied 0; a stalled burst holds forever.

Decomposition:
- Package datastream_arbiter_pkg:
  - state enum {IDLE, BURST}
  - function next_grant(req, last), round-robin search
  - localparam ID_W = $clog2(NBSOURCES)
- One natural sub-module: rr_priority_picker (combinational round-robin search). Counter and FSM stay in the top.

Test Plan:
- Reset: hold rst_i=0 with all sources valid -> all outputs 0; release -> one cycle later grant_id_o=0, busy_o=1.
- Single source 2, BURSTLEN=4, ready_i=1, data 0x10..0x13:
  - Analyzer sees exactly 4 words in order.
  - burst_done_o on the 4th transfer.
  - 1 IDLE cycle, then grant 2 again.
- All 4 sources continuously valid -> grant order 0,1,2,3,0; each burst exactly 4 transfers; src_ready_o one-hot or zero every cycle.
- Backpressure: ready_i toggles 1,0,1,0 during source 1 burst -> count advances only on transfers; data stable while ready_i=0.
- Granted source 3 drops valid for 5 cycles mid-burst while source 0 requests -> grant stays 3; burst completes after valid returns.
  - With ARB_TIMEOUT_EN and TIMEOUT=4: timeout_o pulses after 4 idle cycles, next grant 0.
- Reset asserted at the 2nd word of a burst -> outputs 0 asynchronously; after release arbitration restarts from source 0.

Source files
------------

// File: rtl/datastream_arbiter_pkg.sv
// rtl/datastream_arbiter_pkg.sv - shared types and round-robin search for datastream_arbiter
package datastream_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int unsigned MAX_SOURCES = 16;
  localparam int unsigned ID_W        = $clog2(MAX_SOURCES);

  // First set request strictly after last, wrapping modulo nb; returns last when nothing is set.
  function automatic logic [ID_W-1:0] next_grant(input logic [MAX_SOURCES-1:0] req,
                                                 input logic [ID_W-1:0]        last,
                                                 input int unsigned            nb);
    logic [ID_W-1:0] pick;
    logic [ID_W-1:0] idx;
    logic            found;
    pick  = last;
    found = 1'b0;
    for (int unsigned ofs = 1; ofs <= MAX_SOURCES; ofs++) begin
      idx = ID_W'((32'(last) + ofs) % nb);
      if (ofs <= nb && !found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/datastream_arbiter_picker.sv
// rtl/datastream_arbiter_picker.sv - combinational round-robin picker (rr_priority_picker)
module rr_priority_picker
  import datastream_arbiter_pkg::*;
#(
  parameter  int unsigned NBSOURCES = 4,
  localparam int unsigned GID_W     = $clog2(NBSOURCES)
) (
  input  logic [NBSOURCES-1:0] req_i,
  input  logic [GID_W-1:0]     last_i,
  output logic                 any_o,
  output logic [GID_W-1:0]     grant_o
);

  assign any_o   = |req_i;
  assign grant_o = GID_W'(next_grant(MAX_SOURCES'(req_i), ID_W'(last_i), NBSOURCES));

endmodule

// File: rtl/datastream_arbiter.sv
// rtl/datastream_arbiter.sv - burst-locked round-robin arbiter feeding one datastream analyzer
// Optional abort of stalled bursts: define ARB_TIMEOUT_EN.
module datastream_arbiter
  import datastream_arbiter_pkg::*;
#(
  parameter  int unsigned NBSOURCES = 4,
  parameter  int unsigned DATASIZE  = 8,
  parameter  int unsigned BURSTLEN  = 4,
  parameter  int unsigned TIMEOUT   = 16,
  localparam int unsigned GID_W     = $clog2(NBSOURCES)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NBSOURCES*DATASIZE-1:0] src_data_i,
  input  logic [NBSOURCES-1:0]          src_valid_i,
  output logic [NBSOURCES-1:0]          src_ready_o,
  output logic [DATASIZE-1:0]           data_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [GID_W-1:0]              grant_id_o,
  output logic                          busy_o,
  output logic                          burst_done_o,
  output logic                          timeout_o
);

  localparam int unsigned CNT_W = (BURSTLEN > 1) ? $clog2(BURSTLEN) : 1;

  if (NBSOURCES < 2 || NBSOURCES > MAX_SOURCES || BURSTLEN < 1 || TIMEOUT < 1) begin : g_param_check
    $error("datastream_arbiter: parameter out of range");
  end

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [GID_W-1:0]  grant_q, grant_d;
  logic [GID_W-1:0]  last_q, last_d;

  logic              pick_any;
  logic [GID_W-1:0]  pick_id;
  logic              sel_valid;
  logic              xfer;
  logic              abort;
  logic [DATASIZE-1:0] src_words [NBSOURCES];

  rr_priority_picker #(
    .NBSOURCES(NBSOURCES)
  ) u_picker (
    .req_i  (src_valid_i),
    .last_i (last_q),
    .any_o  (pick_any),
    .grant_o(pick_id)
  );

  always_comb begin
    for (int k = 0; k < int'(NBSOURCES); k++) begin
      src_words[k] = src_data_i[k*DATASIZE +: DATASIZE];
    end
  end

  assign sel_valid = src_valid_i[grant_q];

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TO_W-1:0] idle_q, idle_d;

  // Counts consecutive stalled cycles of the granted source; any valid cycle restarts it.
  always_comb begin
    idle_d = '0;
    abort  = 1'b0;
    if (state_q == BURST && !sel_valid) begin
      if (idle_q == TO_W'(TIMEOUT - 1)) begin
        abort = 1'b1;
      end else begin
        idle_d = idle_q + TO_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end
`else
  assign abort = 1'b0;
`endif

  assign timeout_o = abort;

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    grant_d      = grant_q;
    last_d       = last_q;
    data_o       = '0;
    valid_o      = 1'b0;
    src_ready_o  = '0;
    busy_o       = 1'b0;
    burst_done_o = 1'b0;
    xfer         = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick_id;
          last_d  = pick_id;
          count_d = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        busy_o               = 1'b1;
        data_o               = src_words[grant_q];
        valid_o              = sel_valid;
        src_ready_o[grant_q] = ready_i;
        xfer                 = sel_valid & ready_i;
        if (xfer) begin
          if (count_q == CNT_W'(BURSTLEN - 1)) begin
            burst_done_o = 1'b1;
            count_d      = '0;
            state_d      = IDLE;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
        // last_q already holds the aborting source, so the next search starts after it.
        if (abort) begin
          count_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      count_q <= '0;
      grant_q <= '0;
      last_q  <= GID_W'(NBSOURCES - 1);
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  assign grant_id_o = grant_q;

endmodule
